// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks: active-low segment
// patterns (g..a), the decimal-point bit position and the monitor state type.
package seg_pkg;

    localparam logic [6:0] SEG_PAT_0     = 7'b1000000;
    localparam logic [6:0] SEG_PAT_1     = 7'b1111001;
    localparam logic [6:0] SEG_PAT_2     = 7'b0100100;
    localparam logic [6:0] SEG_PAT_3     = 7'b0110000;
    localparam logic [6:0] SEG_PAT_4     = 7'b0011001;
    localparam logic [6:0] SEG_PAT_5     = 7'b0010010;
    localparam logic [6:0] SEG_PAT_6     = 7'b0000010;
    localparam logic [6:0] SEG_PAT_7     = 7'b1111000;
    localparam logic [6:0] SEG_PAT_8     = 7'b0000000;
    localparam logic [6:0] SEG_PAT_9     = 7'b0011000;
    localparam logic [6:0] SEG_PAT_A     = 7'b0001000;
    localparam logic [6:0] SEG_PAT_B     = 7'b0000011;
    localparam logic [6:0] SEG_PAT_C     = 7'b1000110;
    localparam logic [6:0] SEG_PAT_D     = 7'b0100001;
    localparam logic [6:0] SEG_PAT_E     = 7'b0000110;
    localparam logic [6:0] SEG_PAT_F     = 7'b0001110;
    localparam logic [6:0] SEG_PAT_BLANK = 7'b1111111;

    localparam int SEG_DP_BIT = 7;

    typedef enum logic {
        SETTLING,
        CAPTURED
    } seg_mon_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-low seven-segment pattern (g..a) back to a
// hex nibble. hit flags a hex glyph; is_blank flags the all-off pattern.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       hit,
    output logic       is_blank
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can leave one unassigned (no latch).
        nibble   = 4'h0;
        hit      = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG_PAT_0: nibble = 4'h0;
            SEG_PAT_1: nibble = 4'h1;
            SEG_PAT_2: nibble = 4'h2;
            SEG_PAT_3: nibble = 4'h3;
            SEG_PAT_4: nibble = 4'h4;
            SEG_PAT_5: nibble = 4'h5;
            SEG_PAT_6: nibble = 4'h6;
            SEG_PAT_7: nibble = 4'h7;
            SEG_PAT_8: nibble = 4'h8;
            SEG_PAT_9: nibble = 4'h9;
            SEG_PAT_A: nibble = 4'hA;
            SEG_PAT_B: nibble = 4'hB;
            SEG_PAT_C: nibble = 4'hC;
            SEG_PAT_D: nibble = 4'hD;
            SEG_PAT_E: nibble = 4'hE;
            SEG_PAT_F: nibble = 4'hF;
            SEG_PAT_BLANK: begin
                hit      = 1'b0;
                is_blank = 1'b1;
            end
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_display_monitor.sv
// Monitors a multiplexed active-low seven-segment bus, waits for each digit to
// settle and reassembles the displayed hex value. Define SEG_SYNC_EN to add a
// 2-flop input synchronizer when the bus comes from another clock domain.
module seg_display_monitor
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                seg_n,
    input  logic [NUM_DIGITS-1:0]     an_n,
    input  logic                      clear,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     dp,
    output logic [NUM_DIGITS-1:0]     blank,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_valid,
    output logic                      bad_pattern,
    output logic                      bad_select
);

    localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

    logic [7:0]            seg_in;
    logic [NUM_DIGITS-1:0] an_in;

`ifdef SEG_SYNC_EN
    logic [7:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] an_s1, an_s2;

    // Idle bus level is all ones, so the synchronizer resets there too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
            an_s1  <= an_n;
            an_s2  <= an_s1;
        end
    end

    assign seg_in = seg_s2;
    assign an_in  = an_s2;
`else
    assign seg_in = seg_n;
    assign an_in  = an_n;
`endif

    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [7:0]            count;
    seg_mon_state_t        state;
    logic [NUM_DIGITS-1:0] seen;

    logic [3:0]            dec_nibble;
    logic                  dec_hit;
    logic                  dec_blank;

    seg_pattern_decode u_decode (
        .pattern  (seg_q[6:0]),
        .nibble   (dec_nibble),
        .hit      (dec_hit),
        .is_blank (dec_blank)
    );

    logic                  same;
    logic [NUM_DIGITS-1:0] sel;
    logic                  multi_sel;
    logic                  do_capture;
    logic [NUM_DIGITS-1:0] wr_mask;
    logic                  set_bad_sel;
    logic                  set_bad_pat;
    logic                  seen_full;

    assign same        = ({an_in, seg_in} == {an_q, seg_q});
    assign sel         = ~an_q;
    // Clearing the lowest set bit leaves something only if two or more digits are selected.
    assign multi_sel   = (sel & (sel - NUM_DIGITS'(1))) != '0;
    assign do_capture  = (state == SETTLING) && same && (count == LAST_COUNT);
    assign wr_mask     = (do_capture && !multi_sel && (dec_hit || dec_blank)) ? sel : '0;
    assign set_bad_sel = do_capture && multi_sel;
    assign set_bad_pat = do_capture && (sel != '0) && !multi_sel && !dec_hit && !dec_blank;
    assign seen_full   = &seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q        <= '1;
            seg_q       <= '1;
            count       <= '0;
            state       <= SETTLING;
            seen        <= '0;
            value       <= '0;
            dp          <= '0;
            blank       <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            bad_pattern <= 1'b0;
            bad_select  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            an_q  <= an_in;
            seg_q <= seg_in;
            if (clear) begin
                count       <= '0;
                state       <= SETTLING;
                seen        <= '0;
                value       <= '0;
                dp          <= '0;
                blank       <= '0;
                digit_valid <= '0;
                frame_valid <= 1'b0;
                bad_pattern <= 1'b0;
                bad_select  <= 1'b0;
            end else begin
                if (!same) begin
                    count <= '0;
                    state <= SETTLING;
                end else if (state == SETTLING) begin
                    if (count == LAST_COUNT) begin
                        state <= CAPTURED;
                    end else begin
                        count <= count + 8'd1;
                    end
                end

                // A capture landing in the pulse cycle starts the next frame.
                frame_valid <= seen_full;
                seen        <= (seen_full ? '0 : seen) | wr_mask;

                if (set_bad_sel) bad_select  <= 1'b1;
                if (set_bad_pat) bad_pattern <= 1'b1;

                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (wr_mask[i]) begin
                        value[4*i +: 4] <= dec_nibble;
                        blank[i]        <= dec_blank;
                        dp[i]           <= ~seg_q[SEG_DP_BIT];
                        digit_valid[i]  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_display_monitor.sv
// Directed bench for seg_display_monitor: stimulus pushes hand-computed
// snapshots tagged with the clock edge they are due on; a monitor compares them.
module tb_seg_display_monitor;

`ifdef SEG_SYNC_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 9;
`endif
    localparam int HOLD = LAT + 1;

    logic        clk;
    logic        rst_n;
    logic [7:0]  seg_n;
    logic [3:0]  an_n;
    logic        clear;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        bad_pattern;
    logic        bad_select;

    seg_display_monitor #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .clear       (clear),
        .value       (value),
        .dp          (dp),
        .blank       (blank),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .bad_pattern (bad_pattern),
        .bad_select  (bad_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          at_edge;
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  dv;
        logic        fv;
        logic        bp;
        logic        bs;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [15:0] e_value;
    logic [3:0]  e_dp, e_blank, e_dv;
    logic        e_bp, e_bs;

    task automatic check(input exp_t e);
        vectors++;
        if (e.at_edge != edge_cnt || value !== e.value || dp !== e.dp || blank !== e.blank ||
            digit_valid !== e.dv || frame_valid !== e.fv || bad_pattern !== e.bp || bad_select !== e.bs) begin
            miscompares++;
            $display("FAIL %s edge=%0d due=%0d got value=%h dp=%b blank=%b dv=%b fv=%b bp=%b bs=%b want value=%h dp=%b blank=%b dv=%b fv=%b bp=%b bs=%b",
                     e.name, edge_cnt, e.at_edge, value, dp, blank, digit_valid, frame_valid, bad_pattern, bad_select,
                     e.value, e.dp, e.blank, e.dv, e.fv, e.bp, e.bs);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].at_edge <= edge_cnt) check(sb.pop_front());
    end

    task automatic expect_at(input int at, input string nm, input logic fv);
        exp_t e;
        e.at_edge = at;
        e.value   = e_value;
        e.dp      = e_dp;
        e.blank   = e_blank;
        e.dv      = e_dv;
        e.fv      = fv;
        e.bp      = e_bp;
        e.bs      = e_bs;
        e.name    = nm;
        sb.push_back(e);
    endtask

    task automatic set_exp(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                           input logic [3:0] dv, input logic bp, input logic bs);
        e_value = v; e_dp = d; e_blank = b; e_dv = dv; e_bp = bp; e_bs = bs;
    endtask

    // Called on a falling edge: drives the bus, then holds it for n cycles.
    task automatic apply(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        repeat (n) @(negedge clk);
    endtask

    logic [7:0]  scan_pat [4] = '{8'b11111001, 8'b10100100, 8'b10110000, 8'b10011001};
    logic [15:0] scan_val [4] = '{16'h0001, 16'h0021, 16'h0321, 16'h4321};
    logic [3:0]  scan_dv  [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    initial begin
        int t;
        rst_n = 1'b0;
        clear = 1'b0;
        an_n  = 4'b1111;
        seg_n = 8'hFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        set_exp(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        expect_at(edge_cnt + 1, "reset_state", 1'b0);

        // Digit 0 shows "0" with decimal point: captured on the LAT-th edge, not before.
        t = edge_cnt;
        expect_at(t + LAT - 1, "d0_before_dwell", 1'b0);
        set_exp(16'h0000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
        expect_at(t + LAT, "d0_capture", 1'b0);
        apply(4'b1110, 8'b01000000, LAT);

        // Six-cycle hold on digit 1 is too short to capture.
        t = edge_cnt;
        expect_at(t + LAT + 1, "short_hold", 1'b0);
        apply(4'b1101, 8'b10010010, 6);
        apply(4'b1111, 8'hFF, LAT + 2);

        // Scan 1,2,3,4 across digits 0..3; one frame pulse after digit 3.
        for (int k = 0; k < 4; k++) begin
            t = edge_cnt;
            set_exp(scan_val[k], 4'b0000, 4'b0000, scan_dv[k], 1'b0, 1'b0);
            expect_at(t + LAT, $sformatf("scan_d%0d", k), 1'b0);
            expect_at(t + LAT + 1, $sformatf("scan_frame_d%0d", k), (k == 3));
            apply(~(4'b0001 << k), scan_pat[k], HOLD);
        end
        expect_at(edge_cnt + 1, "frame_pulse_end", 1'b0);

        // Blank on digit 2, then an unknown pattern on digit 1.
        t = edge_cnt;
        set_exp(16'h4021, 4'b0000, 4'b0100, 4'b1111, 1'b0, 1'b0);
        expect_at(t + LAT, "blank_d2", 1'b0);
        apply(4'b1011, 8'b11111111, HOLD);
        t = edge_cnt;
        set_exp(16'h4021, 4'b0000, 4'b0100, 4'b1111, 1'b1, 1'b0);
        expect_at(t + LAT, "bad_pattern_d1", 1'b0);
        apply(4'b1101, 8'b10000001, HOLD);

        // Two digits selected at once, then nothing selected.
        t = edge_cnt;
        set_exp(16'h4021, 4'b0000, 4'b0100, 4'b1111, 1'b1, 1'b1);
        expect_at(t + LAT, "bad_select", 1'b0);
        apply(4'b1100, 8'b11111001, 20);
        t = edge_cnt;
        expect_at(t + LAT, "idle_no_capture", 1'b0);
        expect_at(t + 19, "idle_long", 1'b0);
        apply(4'b1111, 8'hFF, 20);

        // One-cycle glitch at count 5 restarts the dwell.
        apply(4'b0111, 8'b10010010, 6);
        apply(4'b0111, 8'b10000001, 1);
        t = edge_cnt;
        expect_at(t + LAT - 1, "glitch_no_early", 1'b0);
        set_exp(16'h5021, 4'b0000, 4'b0100, 4'b1111, 1'b1, 1'b1);
        expect_at(t + LAT, "glitch_capture", 1'b0);
        apply(4'b0111, 8'b10010010, HOLD);

        // Clear on the same edge as a pending capture wins.
        t = edge_cnt;
        expect_at(t + LAT - 1, "pre_clear", 1'b0);
        apply(4'b1110, 8'b11111000, LAT - 1);
        clear = 1'b1;
        set_exp(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        expect_at(t + LAT, "clear_vs_capture", 1'b0);
        @(negedge clk);
        clear = 1'b0;
        t = edge_cnt;
        expect_at(t + LAT + 2, "after_clear", 1'b0);
        apply(4'b1111, 8'hFF, LAT + 3);

        // Asynchronous reset mid-settle, then a full dwell after release.
        t = edge_cnt;
        set_exp(16'h0009, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);
        expect_at(t + LAT, "pre_reset_capture", 1'b0);
        apply(4'b1110, 8'b10011000, HOLD);
        apply(4'b1101, 8'b10001000, 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        set_exp(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        expect_at(edge_cnt, "async_reset", 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = edge_cnt;
        expect_at(t + LAT - 1, "post_reset_dwell", 1'b0);
        set_exp(16'h00A0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0);
        expect_at(t + LAT, "post_reset_capture", 1'b0);
        repeat (LAT + 2) @(negedge clk);

        for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s never checked (due edge %0d, now %0d)", e.name, e.at_edge, edge_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
